uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares one UART transmitter among NUM_REQ byte producers. Round-robin arbitration with packet lock: a granted requester keeps the transmitter until it sends a byte marked last, or until MAX_BURST bytes. Sits between client logic and the uart transmitter, driving its start/byte inputs and consuming its busy/done status. A watchdog releases the grant if the transmitter never reports done.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
MAX_BURST, 16, max bytes per grant before forced release (>=1)
TIMEOUT_CYCLES, 1024, cycles in WAIT without tx_done before abort (>=16)

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester byte available; must hold until its req_ready
req_data  input  NUM_REQ x 8  per-requester byte, packed [NUM_REQ-1:0][7:0]
req_last  input  NUM_REQ  byte is last of packet
req_ready  output  NUM_REQ  one-hot accept strobe; byte taken when valid&ready
tx_start  output  1  one-cycle start pulse to transmitter
tx_byte  output  8  registered byte to transmitter, stable from LOAD to next LOAD
tx_busy  input  1  transmitter frame in progress
tx_done  input  1  one-cycle pulse, stop bit finished
grant_valid  output  1  a requester currently holds the transmitter
grant_id  output  clog2(NUM_REQ)  holder index, valid when grant_valid
timeout  output  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset: state IDLE, rr pointer 0, burst count 0, watchdog 0; req_ready 0, tx_start 0, tx_byte 8'h00, grant_valid 0, grant_id 0, timeout 0. Reset at any point aborts immediately; partial packet is dropped, transmitter is reset by its own rst.
- States: IDLE, LOAD, ISSUE, WAIT.
- IDLE: if any req_valid, pick first valid index searching pointer, pointer+1, ... wrapping mod NUM_REQ; register grant_id, grant_valid=1, burst count 0 -> LOAD. Else stay.
- LOAD: req_ready[grant_id]=1 (all other bits 0) for exactly this cycle. If req_valid[grant_id]: register tx_byte, last flag, burst count+1 -> ISSUE. If not valid (protocol violation): grant_valid=0, pointer unchanged -> IDLE.
- ISSUE: if tx_busy=0, tx_start=1 this cycle -> WAIT; else hold, tx_start=0.
- WAIT: watchdog increments each cycle. On tx_done: watchdog cleared; if last flag set or burst count==MAX_BURST, pointer=grant_id+1 (wraps NUM_REQ-1 -> 0), grant_valid=0 -> IDLE; else -> LOAD (same grant). If watchdog reaches TIMEOUT_CYCLES-1 without tx_done: timeout=1 for one cycle, release as above -> IDLE.
- tx_done outside WAIT is ignored. tx_done on the timeout cycle counts as done (no timeout pulse).
- Latency: valid seen in IDLE at cycle t -> req_ready at t+1 -> tx_start at t+2 (if not busy). Back-to-back burst bytes: tx_done at t -> req_ready t+1 -> tx_start t+2.
- After forced release (MAX_BURST or timeout), remaining bytes of that requester re-arbitrate normally; no packet-boundary guarantee.

Decomposition:
- uartUtil package: add arb_states_t enum {IDLE, LOAD, ISSUE, WAIT}, named distinctly from the existing receiver states_t.
- Sub-module rr_picker: combinational, inputs req vector + pointer, outputs found flag + index; parameterised on NUM_REQ.
- Counters and FSM live in uart_tx_arbiter.

Test Plan:
- Single: req 2 valid, data 8'hA5, last=1 at cycle 0 -> req_ready=4'b0100 at cycle 1, tx_start with tx_byte=8'hA5 at cycle 2; tx_done at 12 -> grant_valid=0 at 13, next grant search starts at 3.
- Fairness: all 4 valid, last=1, continuously after reset -> grant_id sequence 0,1,2,3,0; exactly one tx_start per tx_done.
- Packet lock: req1 sends 8'h11,8'h22,8'h33 (last on 8'h33) while req0 valid -> req0 not granted until cycle after 8'h33's tx_done.
- Burst cap: MAX_BURST=4, req3 sends 6 bytes no last, req0 valid -> after 4th tx_done grant moves to 0; req3 regains later and sends bytes 5, 6.
- Busy hold: tx_busy high 5 cycles in ISSUE -> tx_start 0 throughout, single pulse in first cycle tx_busy=0.
- Timeout/reset: TIMEOUT_CYCLES=16, no tx_done -> timeout pulse 16 cycles after tx_start, IDLE, pointer advanced; separately rst mid-WAIT -> all outputs at reset values next cycle, pointer 0.

Source files
------------

// File: rtl/uart_util_pkg.sv
// Shared UART utility definitions. Holds the transmit-arbiter state encoding,
// kept separate from the receiver's states_t.
package uartUtil;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ISSUE,
        WAIT
    } arb_states_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin search: first asserted request at ptr, ptr+1, ...
// wrapping modulo NUM_REQ.
module rr_picker #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic                       found,
    output logic [$clog2(NUM_REQ)-1:0] idx
);

    localparam int IW = $clog2(NUM_REQ);

    int          cand;
    logic [IW-1:0] cand_idx;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the loop can leave it unassigned and infer a latch.
    always_comb begin
        found    = 1'b0;
        idx      = '0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            cand_idx = IW'(cand);
            if (!found && req[cand_idx]) begin
                found = 1'b1;
                idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte producers: round-robin grant,
// held until a last byte, MAX_BURST bytes, or a watchdog abort.
module uart_tx_arbiter
    import uartUtil::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int MAX_BURST      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0][7:0]    req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_start,
    output logic [7:0]                 tx_byte,
    input  logic                       tx_busy,
    input  logic                       tx_done,
    output logic                       grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       timeout
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES);

    arb_states_t   state, state_next;
    logic [IW-1:0] ptr, ptr_after, pick_idx;
    logic          pick_found;
    logic [BW-1:0] burst;
    logic [WW-1:0] wd;
    logic          last_flag;
    logic          held_valid, burst_end, wd_expired;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req   (req_valid),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign held_valid = req_valid[grant_id];
    assign burst_end  = last_flag || (burst == BW'(MAX_BURST));
    assign wd_expired = (wd == WW'(TIMEOUT_CYCLES - 1));
    // Explicit wrap so non-power-of-two NUM_REQ never lands on an unused index.
    assign ptr_after  = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + IW'(1);

    always_comb begin
        state_next = state;
        req_ready  = '0;
        tx_start   = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: if (pick_found) state_next = LOAD;
            LOAD: begin
                req_ready[grant_id] = 1'b1;
                state_next          = held_valid ? ISSUE : IDLE;
            end
            ISSUE: if (!tx_busy) begin
                tx_start   = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                // A done arriving on the expiry cycle wins over the abort.
                if (tx_done) begin
                    state_next = burst_end ? IDLE : LOAD;
                end else if (wd_expired) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            burst       <= '0;
            wd          <= '0;
            last_flag   <= 1'b0;
            tx_byte     <= 8'h00;
            grant_valid <= 1'b0;
            grant_id    <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (pick_found) begin
                    grant_id    <= pick_idx;
                    grant_valid <= 1'b1;
                    burst       <= '0;
                end
                LOAD: begin
                    if (held_valid) begin
                        tx_byte   <= req_data[grant_id];
                        last_flag <= req_last[grant_id];
                        burst     <= burst + BW'(1);
                    end else begin
                        grant_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    if (tx_done || wd_expired) begin
                        wd <= '0;
                        if (!tx_done || burst_end) begin
                            ptr         <= ptr_after;
                            grant_valid <= 1'b0;
                        end
                    end else begin
                        wd <= wd + WW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: a transaction-level service model predicts the order of
// (requester, byte) frames; a monitor with a transmitter model checks each start.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ        = 4;
    localparam int MAX_BURST      = 4;
    localparam int TIMEOUT_CYCLES = 16;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } beat_t;

    typedef struct {
        int         id;
        logic [7:0] data;
        bit         drop;
        int         delay;
        int         extra;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [NUM_REQ-1:0]      req_valid = '0;
    logic [NUM_REQ-1:0][7:0] req_data = '0;
    logic [NUM_REQ-1:0]      req_last = '0;
    logic [NUM_REQ-1:0]      req_ready;
    logic                    tx_start;
    logic [7:0]              tx_byte;
    logic                    tx_busy = 1'b0;
    logic                    tx_done = 1'b0;
    logic                    grant_valid;
    logic [1:0]              grant_id;
    logic                    timeout;

    uart_tx_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .MAX_BURST      (MAX_BURST),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_byte     (tx_byte),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    int    n_tests = 0;
    int    n_fail  = 0;
    beat_t drv_q[NUM_REQ][$];
    beat_t mdl_q[NUM_REQ][$];
    exp_t  exp_q[$];
    int    mdl_ptr = 0;
    int    n_starts = 0;
    bit    pending = 0;
    int    busy_tail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_beat(input int id, input logic [7:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        drv_q[id].push_back(b);
        mdl_q[id].push_back(b);
    endtask

    // Service order from the rules: grant the first non-empty queue from the
    // pointer, serve until a last byte, MAX_BURST bytes, or an aborted frame.
    task automatic gen_expected(input int drop_pct, input int fix_delay);
        int    id, cnt;
        bit    found;
        beat_t b;
        exp_t  e;
        forever begin
            found = 0;
            id    = 0;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!found && mdl_q[(mdl_ptr + k) % NUM_REQ].size() > 0) begin
                    found = 1;
                    id    = (mdl_ptr + k) % NUM_REQ;
                end
            end
            if (!found) break;
            cnt = 0;
            forever begin
                b = mdl_q[id].pop_front();
                cnt++;
                e.id   = id;
                e.data = b.data;
                e.drop = ($urandom_range(0, 99) < drop_pct);
                if (fix_delay > 0) begin
                    e.delay = fix_delay;
                    e.extra = 0;
                end else begin
                    case ($urandom_range(0, 9))
                        0: e.delay = 1;
                        1: e.delay = 2;
                        2: e.delay = 3;
                        3: e.delay = 4;
                        4: e.delay = 5;
                        5: e.delay = 7;
                        6: e.delay = 9;
                        7: e.delay = 15;
                        8: e.delay = 16;
                        default: e.delay = 2;
                    endcase
                    e.extra = $urandom_range(0, 7);
                end
                exp_q.push_back(e);
                if (b.last || cnt == MAX_BURST || e.drop) begin
                    mdl_ptr = (id + 1) % NUM_REQ;
                    break;
                end
            end
        end
    endtask

    function automatic bit all_empty();
        bit r = 1;
        for (int i = 0; i < NUM_REQ; i++) if (drv_q[i].size() != 0) r = 0;
        return r;
    endfunction

    task automatic drain(input string name);
        bit ok = 0;
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            #3;
            if (exp_q.size() == 0 && !pending && busy_tail == 0 && !grant_valid && all_empty()) begin
                ok = 1;
                break;
            end
        end
        check(name, ok, 1);
    endtask

    task automatic wait_start(input string name);
        int base = n_starts;
        bit ok   = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            #3;
            if (n_starts > base) begin
                ok = 1;
                break;
            end
        end
        check(name, ok, 1);
    endtask

    // Requester drivers: present queue heads, pop after an accepted handshake.
    initial begin : drivers
        logic [NUM_REQ-1:0] taken;
        taken = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++)
                if (taken[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
            for (int i = 0; i < NUM_REQ; i++) begin
                if (drv_q[i].size() > 0) begin
                    req_valid[i] = 1'b1;
                    req_data[i]  = drv_q[i][0].data;
                    req_last[i]  = drv_q[i][0].last;
                end else begin
                    req_valid[i] = 1'b0;
                    req_data[i]  = 8'h00;
                    req_last[i]  = 1'b0;
                end
            end
            #1;
            taken = rst ? '0 : (req_valid & req_ready);
        end
    end

    // Transmitter model plus scoreboard monitor.
    initial begin : monitor
        int   cyc, done_cyc, to_cyc, extra_cur;
        bit   drop_cur, exp_to;
        exp_t e;
        cyc = 0; done_cyc = 0; to_cyc = 0; extra_cur = 0; drop_cur = 0;
        forever begin
            @(negedge clk);
            cyc++;
            tx_done = 1'b0;
            if (rst) begin
                pending   = 0;
                busy_tail = 0;
                tx_busy   = 1'b0;
                continue;
            end
            if (pending && !drop_cur && cyc == done_cyc) begin
                tx_done   = 1'b1;
                pending   = 0;
                busy_tail = extra_cur;
            end
            tx_busy = pending || (busy_tail > 0);
            if (busy_tail > 0) busy_tail--;
            #2;
            exp_to = pending && drop_cur && (cyc == to_cyc);
            if (timeout || exp_to) begin
                check("timeout_pulse", timeout, exp_to);
                if (exp_to) pending = 0;
            end
            if (tx_start) begin
                n_starts++;
                check("start_not_busy", tx_busy, 0);
                check("start_one_per_done", pending, 0);
                if (exp_q.size() == 0) begin
                    check("start_expected", 0, 1);
                end else begin
                    e = exp_q.pop_front();
                    check("grant_valid_at_start", grant_valid, 1);
                    check("grant_id", grant_id, e.id);
                    check("tx_byte", tx_byte, e.data);
                    pending   = 1;
                    drop_cur  = e.drop;
                    done_cyc  = cyc + e.delay;
                    to_cyc    = cyc + TIMEOUT_CYCLES;
                    extra_cur = e.extra;
                end
            end
        end
    end

    initial begin : global_limit
        #600000;
        $display("FAIL global_timeout: got no end, expected summary");
        $fatal(1, "simulation limit");
    end

    initial begin : main
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_byte", tx_byte, 8'h00);
        check("rst_grant_valid", grant_valid, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_timeout", timeout, 0);
        rst = 1'b0;

        // Fairness from reset: expected order 0,1,2,3.
        @(posedge clk); #1;
        for (int i = 0; i < NUM_REQ; i++) push_beat(i, 8'(8'h40 + i), 1'b1);
        gen_expected(0, 0);
        drain("fair_drain");

        // Packet lock: requester 1 holds across 3 bytes while 2 waits.
        @(posedge clk); #1;
        push_beat(1, 8'h11, 1'b0);
        push_beat(1, 8'h22, 1'b0);
        push_beat(1, 8'h33, 1'b1);
        push_beat(2, 8'h77, 1'b1);
        gen_expected(0, 0);
        drain("lock_drain");

        // Burst cap: requester 3 is cut after MAX_BURST bytes, 0 gets a turn.
        @(posedge clk); #1;
        for (int b = 0; b < 6; b++) push_beat(3, 8'(8'hD0 + b), b == 5);
        push_beat(0, 8'h0F, 1'b1);
        gen_expected(0, 0);
        drain("burst_drain");

        // Single-byte latency: ready at t+1, start at t+2, release after done.
        @(posedge clk); #1;
        push_beat(2, 8'hA5, 1'b1);
        gen_expected(0, 10);
        @(negedge clk);
        @(negedge clk); #3;
        check("single_ready_t1", req_ready, 4'b0100);
        @(negedge clk); #3;
        check("single_start_t2", tx_start, 1);
        check("single_byte_t2", tx_byte, 8'hA5);
        repeat (10) @(negedge clk);
        #3;
        check("single_grant_on_done", grant_valid, 1);
        @(negedge clk); #3;
        check("single_grant_released", grant_valid, 0);
        drain("single_drain");

        // Move the pointer to 2, then reset in the middle of a WAIT.
        @(posedge clk); #1;
        push_beat(1, 8'h5C, 1'b1);
        gen_expected(0, 3);
        drain("pre_rst_drain");
        @(posedge clk); #1;
        push_beat(3, 8'hC3, 1'b1);
        gen_expected(0, 12);
        wait_start("rst_wait_start");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_req_ready", req_ready, 0);
        check("midrst_tx_start", tx_start, 0);
        check("midrst_tx_byte", tx_byte, 8'h00);
        check("midrst_grant_valid", grant_valid, 0);
        check("midrst_grant_id", grant_id, 0);
        check("midrst_timeout", timeout, 0);
        for (int i = 0; i < NUM_REQ; i++) begin
            drv_q[i].delete();
            mdl_q[i].delete();
        end
        exp_q.delete();
        mdl_ptr = 0;
        rst = 1'b0;
        @(posedge clk); #1;
        push_beat(0, 8'h01, 1'b1);
        push_beat(2, 8'h02, 1'b1);
        gen_expected(0, 0);
        drain("post_rst_drain");

        // Random rounds with aborted frames, busy stretches and done-at-expiry.
        repeat (20) begin
            @(posedge clk); #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                int np;
                np = $urandom_range(0, 2);
                for (int p = 0; p < np; p++) begin
                    int len;
                    len = $urandom_range(1, 6);
                    for (int b = 0; b < len; b++) push_beat(i, 8'($urandom), b == len - 1);
                end
            end
            gen_expected(12, 0);
            drain("rand_drain");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
